// File: rtl/reg_f_stack_pkg.sv
// Shared definitions for the register-file context stack and its sequencer.
// Holds the sequencer state set, the stack address width and the reserved slot.
package reg_f_stack_pkg;

    localparam int unsigned STK_ADDR_W        = 6;
    localparam int unsigned STK_DEFAULT_DEPTH = 8;

    // Slot 0 never holds a frame; an empty stack points here.
    localparam logic [STK_ADDR_W-1:0] STK_NONE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_SET,
        ST_PUSH_WR,
        ST_POP_SET,
        ST_POP_RD,
        ST_POP_LD,
        ST_DONE
    } stk_state_e;

    // A request is refused when it is ambiguous or would over/underflow the stack.
    function automatic logic stk_req_rejected(
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        return (push && pop) || (push && full) || (pop && empty);
    endfunction

endpackage

// File: rtl/reg_f_stack_ctrl.sv
// Sequencer turning push/pop requests into addr/wren timing for reg_f_stack.
// Tracks the stack pointer and raises a restore strobe for the popped frame.
module reg_f_stack_ctrl
    import reg_f_stack_pkg::*;
#(
    parameter int unsigned ADDR_W = STK_ADDR_W,
    parameter int unsigned DEPTH  = STK_DEFAULT_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push_req,
    input  logic              i_pop_req,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_stk_addr,
    output logic              o_stk_wren,
    output logic              o_restore_en
);

    localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(STK_NONE);

    stk_state_e        r_state;
    stk_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] w_sp_nxt;
    logic              w_err_nxt;
    logic [ADDR_W-1:0] w_stk_addr_nxt;

    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic              r_full;
    logic              r_empty;
    logic [ADDR_W-1:0] r_stk_addr;
    logic              r_stk_wren;
    logic              r_restore_en;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, stack pointer update and request rejection
    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_push_req || i_pop_req) begin
                    if (stk_req_rejected(i_push_req, i_pop_req,
                                         r_sp == SP_FULL, r_sp == SP_EMPTY)) begin
                        w_err_nxt = 1'b1;
                    end else if (i_push_req) begin
                        w_state_nxt = ST_PUSH_SET;
                    end else begin
                        w_state_nxt = ST_POP_SET;
                    end
                end
            end
            ST_PUSH_SET: w_state_nxt = ST_PUSH_WR;
            ST_PUSH_WR: begin
                w_state_nxt = ST_DONE;
                w_sp_nxt    = r_sp + ADDR_W'(1);
            end
            ST_POP_SET: w_state_nxt = ST_POP_RD;
            ST_POP_RD:  w_state_nxt = ST_POP_LD;
            ST_POP_LD: begin
                w_state_nxt = ST_DONE;
                w_sp_nxt    = r_sp - ADDR_W'(1);
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Push targets the slot above the top; everything else shows the top frame.
    always_comb begin
        w_stk_addr_nxt = w_sp_nxt;
        if ((w_state_nxt == ST_PUSH_SET) || (w_state_nxt == ST_PUSH_WR)) begin
            w_stk_addr_nxt = w_sp_nxt + ADDR_W'(1);
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sp         <= SP_EMPTY;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_stk_addr   <= SP_EMPTY;
            r_stk_wren   <= 1'b0;
            r_restore_en <= 1'b0;
        end else begin
            r_sp         <= w_sp_nxt;
            r_ready      <= (w_state_nxt == ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
            r_err        <= w_err_nxt;
            r_full       <= (w_sp_nxt == SP_FULL);
            r_empty      <= (w_sp_nxt == SP_EMPTY);
            r_stk_addr   <= w_stk_addr_nxt;
            r_stk_wren   <= (w_state_nxt == ST_PUSH_WR);
            r_restore_en <= (w_state_nxt == ST_POP_LD);
        end
    end

    assign o_ready      = r_ready;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_full       = r_full;
    assign o_empty      = r_empty;
    assign o_sp         = r_sp;
    assign o_stk_addr   = r_stk_addr;
    assign o_stk_wren   = r_stk_wren;
    assign o_restore_en = r_restore_en;

endmodule
